seq_shift_add_multiplier: RTL and testbench



---
 rtl/seq_shift_add_multiplier.sv | 115 +++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_multiplier.sv
// ============================================================================
// Module   : seq_shift_add_multiplier
// Brief    : Iterative unsigned shift-add multiplier with valid/ready on both
//            sides. Optional early termination via SEQ_MUL_EARLY_TERM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_busy;

  logic [2*WIDTH-1:0]   w_sum;
  logic                 w_last;

  assign w_sum = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

`ifdef SEQ_MUL_EARLY_TERM_EN
  // Stop once no set multiplier bits remain after this step.
  assign w_last = (r_cnt == c_LAST) || (r_mplier[WIDTH-1:1] == '0);
`else
  assign w_last = (r_cnt == c_LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_product   <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mcand    <= {{WIDTH{1'b0}}, a};
            r_mplier   <= b;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_state    <= S_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_product   <= w_sum;
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign product   = r_product;

endmodule

`default_nettype wire

// File: tb/tb_seq_shift_add_multiplier.sv
// ============================================================================
// Module   : tb_seq_shift_add_multiplier
// Brief    : Self-checking bench: vector table, scoreboard queue, corner cases.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_shift_add_multiplier;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [2*WIDTH-1:0] sb[$];
  int                 hs_cyc[$];

  typedef struct {
    logic [WIDTH-1:0]   va;
    logic [WIDTH-1:0]   vb;
    logic [2*WIDTH-1:0] vexp;
    int                 hold;
  } vec_t;

  vec_t vecs[8];

  seq_shift_add_multiplier #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_lat(input logic [WIDTH-1:0] vb);
    int l;
`ifdef SEQ_MUL_EARLY_TERM_EN
    l = 1;
    for (int i = 0; i < WIDTH; i++) if (vb[i]) l = i + 1;
`else
    l = WIDTH;
`endif
    return l;
  endfunction

  // Scoreboard consumer: a result leaves on every out_valid & out_ready edge.
  always @(negedge clk) begin : mon
    logic [2*WIDTH-1:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_output", 32'(product), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("sb_product", 32'(product), 32'(e));
      end
      hs_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                       input logic [2*WIDTH-1:0] e, input int hold);
    int n;
    int busy_n;
    a = ta; b = tb_; in_valid = 1'b1; out_ready = 1'b0;
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    sb.push_back(e);
    step();
    in_valid = 1'b0;
    n = 0; busy_n = 0;
    while (!out_valid && n < 64) begin
      if (busy) busy_n++;
      step();
      n++;
    end
    chk("latency", n, exp_lat(tb_));
    chk("busy_cycles", busy_n, exp_lat(tb_));
    for (int k = 0; k < hold; k++) begin
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_product", 32'(product), 32'(e));
      in_valid = (k == 1);
      a = 8'd1; b = 8'd1;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("post_hs_product_held", 32'(product), 32'(e));
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic [WIDTH-1:0] pa[3];
    logic [WIDTH-1:0] pb[3];
    int               base;
    int               n;

    vecs[0] = '{8'd13,  8'd11,  16'd143,   0};
    vecs[1] = '{8'd255, 8'd255, 16'd65025, 0};
    vecs[2] = '{8'd0,   8'd200, 16'd0,     0};
    vecs[3] = '{8'd200, 8'd0,   16'd0,     0};
    vecs[4] = '{8'd7,   8'd9,   16'd63,    5};
    vecs[5] = '{8'd50,  8'd3,   16'd150,   0};
    vecs[6] = '{8'd2,   8'h80,  16'd256,   0};
    vecs[7] = '{8'd1,   8'd1,   16'd1,     2};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #23;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++)
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vexp, vecs[i].hold);

    // Asynchronous reset in the third RUN cycle discards the operation.
    a = 8'd100; b = 8'd100; in_valid = 1'b1;
    sb.push_back(16'd10000);
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("midop_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midop_rst_out_valid", 32'(out_valid), 32'd0);
    chk("midop_rst_product", 32'(product), 32'd0);
    chk("midop_rst_in_ready", 32'(in_ready), 32'd1);
    chk("midop_rst_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    do_op(8'd12, 8'd12, 16'd144, 0);

    // Back-to-back with in_valid held and out_ready high.
    pa[0] = 8'd3;   pb[0] = 8'd5;
    pa[1] = 8'd250; pb[1] = 8'd2;
    pa[2] = 8'd17;  pb[2] = 8'd17;
    base = hs_cyc.size();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!in_ready && n < 64) begin step(); n++; end
      chk("b2b_wait_in_ready", 32'(in_ready), 32'd1);
      a = pa[i]; b = pb[i]; in_valid = 1'b1;
      sb.push_back(16'(pa[i]) * 16'(pb[i]));
      step();
    end
    in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 100) begin step(); n++; end
    chk("b2b_drained", sb.size(), 0);
    chk("b2b_count", hs_cyc.size() - base, 3);
    if (hs_cyc.size() - base == 3) begin
      chk("b2b_spacing1", hs_cyc[base+1] - hs_cyc[base], exp_lat(pb[1]) + 2);
      chk("b2b_spacing2", hs_cyc[base+2] - hs_cyc[base+1], exp_lat(pb[2]) + 2);
    end
    step();
    out_ready = 1'b0;

    // Random sweep against the arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      do_op(ra, rb, 16'(ra) * 16'(rb), 0);
    end

    n = 0;
    while (sb.size() != 0 && n < 50) begin step(); n++; end
    chk("final_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
